// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - funct3 codes, FSM encoding and size helpers for the MEM stage
package mem_stage_pkg;

    localparam int XLEN_DEFAULT = 64;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACCESS = 1'b1;

    // Byte-lane mask for an access of the given size code (funct3[1:0]).
    function automatic logic [7:0] size_mask(input logic [1:0] size_code);
        case (size_code)
            2'b00:   size_mask = 8'h01;
            2'b01:   size_mask = 8'h03;
            2'b10:   size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
    endfunction

    // Address bits that must be zero for a naturally aligned access.
    function automatic logic [2:0] align_mask(input logic [1:0] size_code);
        case (size_code)
            2'b00:   align_mask = 3'b000;
            2'b01:   align_mask = 3'b001;
            2'b10:   align_mask = 3'b011;
            default: align_mask = 3'b111;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte-lane steering for stores and load extract/extend
module mem_lane_align
    import mem_stage_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [2:0]      offset_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] store_data_i,
    input  logic [XLEN-1:0] rdata_i,
    output logic [7:0]      wstrb_o,
    output logic [XLEN-1:0] wdata_o,
    output logic [XLEN-1:0] load_data_o
);

    logic [5:0]      shamt;
    logic [XLEN-1:0] shifted;

    assign shamt = {offset_i, 3'b000};

    // Lanes pushed past byte 7 fall off the top; lanes pulled from past byte 7 read as zero.
    assign wstrb_o = size_mask(funct3_i[1:0]) << offset_i;
    assign wdata_o = store_data_i << shamt;
    assign shifted = rdata_i >> shamt;

    always_comb begin
        load_data_o = shifted;
        case (funct3_i)
            F3_B:  load_data_o = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            F3_H:  load_data_o = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            F3_W:  load_data_o = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
            F3_D:  load_data_o = shifted;
            F3_BU: load_data_o = {{(XLEN-8){1'b0}}, shifted[7:0]};
            F3_HU: load_data_o = {{(XLEN-16){1'b0}}, shifted[15:0]};
            F3_WU: load_data_o = {{(XLEN-32){1'b0}}, shifted[31:0]};
            default: load_data_o = shifted;
        endcase
    end

endmodule

// File: rtl/mem_stage_unit.sv
// rtl/mem_stage_unit.sv - MEM stage: data-memory req/ack access FSM, branch resolve, MEM/WB register
// Optional build macro: MEM_MISALIGN_TRAP_EN (misaligned accesses complete with mem_err, no request).
module mem_stage_unit
    import mem_stage_pkg::*;
#(
    parameter int XLEN     = XLEN_DEFAULT,
    parameter int MAX_WAIT = 255
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    input  logic [XLEN-1:0] PC_S,
    input  logic            RegWrite_S,
    input  logic            MemtoReg_S,
    input  logic            MemRead_S,
    input  logic            MemWrite_S,
    input  logic            Branch_S,
    input  logic            ZERO_S,
    input  logic [XLEN-1:0] Result_S,
    input  logic [XLEN-1:0] Write_Data_Mem_S,
    input  logic [XLEN-1:0] Branch_Address_S,
    input  logic [3:0]      Funct_S,
    input  logic [4:0]      RD_S,
    output logic            stall,
    output logic            PCSrc,
    output logic [XLEN-1:0] Branch_Target,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [7:0]      mem_wstrb,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ack,
    output logic            wb_valid,
    output logic            RegWrite_W,
    output logic            MemtoReg_W,
    output logic [XLEN-1:0] Read_Data_W,
    output logic [XLEN-1:0] Result_W,
    output logic [XLEN-1:0] PC_W,
    output logic [4:0]      RD_W,
    output logic            mem_err
);

    localparam int            CW       = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] WAIT_MAX = CW'(MAX_WAIT);

    logic [0:0]      state_q, state_d;
    logic [CW-1:0]   wait_cnt_q, wait_cnt_d;
    logic            memop, trap, access_ok, timeout, timeout_fail, done, complete, load_ack;
    logic [XLEN-1:0] load_data;
    logic            unused_funct;

    assign unused_funct = Funct_S[3];

    assign memop = in_valid & (MemRead_S | MemWrite_S);

`ifdef MEM_MISALIGN_TRAP_EN
    assign trap = memop & (|(Result_S[2:0] & align_mask(Funct_S[1:0])));
`else
    assign trap = 1'b0;
`endif

    assign access_ok    = memop & ~trap;
    assign timeout      = (state_q == ST_ACCESS) & (wait_cnt_q == WAIT_MAX);
    assign timeout_fail = timeout & ~mem_ack;
    assign done         = access_ok & (mem_ack | timeout);
    assign complete     = in_valid & (~memop | trap | done);
    assign load_ack     = access_ok & MemRead_S & ~MemWrite_S & mem_ack;

    // Gated by reset so the request and stall fall immediately, not at the next edge.
    assign mem_req  = access_ok & ~reset;
    assign stall    = access_ok & ~mem_ack & ~timeout & ~reset;
    assign mem_we   = mem_req & MemWrite_S;
    assign mem_addr = {Result_S[XLEN-1:3], 3'b000};

    assign PCSrc         = in_valid & Branch_S & ZERO_S;
    assign Branch_Target = Branch_Address_S;

    mem_lane_align #(.XLEN(XLEN)) u_align (
        .offset_i     (Result_S[2:0]),
        .funct3_i     (Funct_S[2:0]),
        .store_data_i (Write_Data_Mem_S),
        .rdata_i      (mem_rdata),
        .wstrb_o      (mem_wstrb),
        .wdata_o      (mem_wdata),
        .load_data_o  (load_data)
    );

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        if (state_q == ST_IDLE) begin
            wait_cnt_d = '0;
            if (access_ok & ~mem_ack) begin
                state_d = ST_ACCESS;
            end
        end else begin
            // Losing the request mid-access is treated like completion so the FSM never wedges.
            if (mem_ack | timeout | ~access_ok) begin
                state_d    = ST_IDLE;
                wait_cnt_d = '0;
            end else if (wait_cnt_q != WAIT_MAX) begin
                wait_cnt_d = wait_cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            wait_cnt_q  <= '0;
            wb_valid    <= 1'b0;
            mem_err     <= 1'b0;
            RegWrite_W  <= 1'b0;
            MemtoReg_W  <= 1'b0;
            Read_Data_W <= '0;
            Result_W    <= '0;
            PC_W        <= '0;
            RD_W        <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            wb_valid   <= complete;
            mem_err    <= complete & (trap | timeout_fail);
            if (complete) begin
                RegWrite_W  <= RegWrite_S & ~trap & ~timeout_fail;
                MemtoReg_W  <= MemtoReg_S;
                Read_Data_W <= load_ack ? load_data : '0;
                Result_W    <= Result_S;
                PC_W        <= PC_S;
                RD_W        <= RD_S;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_unit.sv
// tb/tb_mem_stage_unit.sv - self-checking bench for mem_stage_unit with a byte-level reference model
module tb_mem_stage_unit;

    localparam int XLEN     = 64;
    localparam int MAX_WAIT = 255;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, RegWrite_S, MemtoReg_S, MemRead_S, MemWrite_S, Branch_S, ZERO_S;
    logic [63:0] PC_S, Result_S, Write_Data_Mem_S, Branch_Address_S, mem_rdata;
    logic [3:0]  Funct_S;
    logic [4:0]  RD_S;
    logic        mem_ack;
    logic        stall, PCSrc, mem_req, mem_we, wb_valid, RegWrite_W, MemtoReg_W, mem_err;
    logic [63:0] Branch_Target, mem_addr, mem_wdata, Read_Data_W, Result_W, PC_W;
    logic [7:0]  mem_wstrb;
    logic [4:0]  RD_W;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mem_stage_unit #(.XLEN(XLEN), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .PC_S(PC_S),
        .RegWrite_S(RegWrite_S), .MemtoReg_S(MemtoReg_S), .MemRead_S(MemRead_S),
        .MemWrite_S(MemWrite_S), .Branch_S(Branch_S), .ZERO_S(ZERO_S),
        .Result_S(Result_S), .Write_Data_Mem_S(Write_Data_Mem_S),
        .Branch_Address_S(Branch_Address_S), .Funct_S(Funct_S), .RD_S(RD_S),
        .stall(stall), .PCSrc(PCSrc), .Branch_Target(Branch_Target),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .wb_valid(wb_valid), .RegWrite_W(RegWrite_W),
        .MemtoReg_W(MemtoReg_W), .Read_Data_W(Read_Data_W), .Result_W(Result_W),
        .PC_W(PC_W), .RD_W(RD_W), .mem_err(mem_err)
    );

    // ---------------- reference model (byte-by-byte) ----------------
    function automatic int size_of(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic [7:0] exp_strb(input logic [2:0] f3, input int off);
        logic [7:0] s = '0;
        for (int i = 0; i < size_of(f3); i++)
            if (off + i < 8) s[off + i] = 1'b1;
        return s;
    endfunction

    function automatic logic [63:0] exp_wdata(input logic [63:0] data, input int off);
        logic [63:0] r = '0;
        for (int lane = 0; lane < 8; lane++)
            if (lane >= off) r[lane*8 +: 8] = data[(lane-off)*8 +: 8];
        return r;
    endfunction

    function automatic logic [63:0] exp_load(input logic [63:0] rdata, input logic [2:0] f3, input int off);
        logic [63:0] v = '0;
        int n = size_of(f3);
        for (int i = 0; i < n; i++)
            if (off + i < 8) v[i*8 +: 8] = rdata[(off+i)*8 +: 8];
        if (n < 8 && !f3[2] && v[8*n-1])
            for (int b = 8*n; b < 64; b++) v[b] = 1'b1;
        return v;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic idle_inputs();
        in_valid = 0; RegWrite_S = 0; MemtoReg_S = 0; MemRead_S = 0; MemWrite_S = 0;
        Branch_S = 0; ZERO_S = 0; PC_S = 0; Result_S = 0; Write_Data_Mem_S = 0;
        Branch_Address_S = 0; Funct_S = 0; RD_S = 0;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [63:0] addr, input logic [63:0] data, input logic rw);
        in_valid = 1; MemRead_S = rd; MemWrite_S = wr; RegWrite_S = rw; MemtoReg_S = rd;
        Funct_S = {1'($urandom_range(0, 1)), f3}; Result_S = addr; Write_Data_Mem_S = data;
        RD_S = 5'($urandom_range(1, 31)); PC_S = {$urandom, $urandom};
        Branch_S = 0; ZERO_S = 0; Branch_Address_S = 0;
    endtask

    // Starts at a negedge with inputs driven; returns 1 time unit after the completion edge.
    task automatic run_txn(input int ack_delay, output int stalls, output int bubbles,
                           output logic req0, output logic we0, output logic [7:0] strb0,
                           output logic [63:0] wdata0, output logic [63:0] addr0, output logic done);
        stalls = 0; bubbles = 0; done = 0; req0 = 0; we0 = 0; strb0 = 0; wdata0 = 0; addr0 = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            mem_ack = (cyc == ack_delay);
            #1;
            if (cyc == 0) begin
                req0 = mem_req; we0 = mem_we; strb0 = mem_wstrb; wdata0 = mem_wdata; addr0 = mem_addr;
            end
            if (cyc > 0 && wb_valid) bubbles++;
            if (!stall) begin
                done = 1;
                @(posedge clk);
                #1;
                break;
            end
            stalls++;
            @(negedge clk);
        end
        mem_ack = 0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk);
        #1;
        tests++; if (wb_valid !== 1'b0) begin fails++; $display("FAIL reset_wb_valid got=%b exp=0", wb_valid); end
        tests++; if (mem_err !== 1'b0) begin fails++; $display("FAIL reset_mem_err got=%b exp=0", mem_err); end
        tests++; if ({RegWrite_W, MemtoReg_W, RD_W} !== 7'd0) begin fails++; $display("FAIL reset_ctrl got=%h exp=0", {RegWrite_W, MemtoReg_W, RD_W}); end
        tests++; if ({Read_Data_W, Result_W, PC_W} !== 192'd0) begin fails++; $display("FAIL reset_data got=%h exp=0", {Read_Data_W, Result_W, PC_W}); end
        tests++; if ({mem_req, stall} !== 2'b00) begin fails++; $display("FAIL reset_req_stall got=%b exp=00", {mem_req, stall}); end
        reset = 0;
    endtask

    task automatic test_sd();
        int st, bb; logic rq, we, dn; logic [7:0] sb; logic [63:0] wd, ad;
        @(negedge clk);
        drive(0, 1, 3'b011, 64'h1000, 64'hDEADBEEF_CAFEF00D, 0);
        run_txn(0, st, bb, rq, we, sb, wd, ad, dn);
        tests++; if (dn !== 1'b1 || st != 0) begin fails++; $display("FAIL sd_stall got=%0d exp=0", st); end
        tests++; if ({rq, we, sb} !== {1'b1, 1'b1, 8'hFF}) begin fails++; $display("FAIL sd_req_we_strb got=%h exp=3ff", {rq, we, sb}); end
        tests++; if (wd !== 64'hDEADBEEF_CAFEF00D || ad !== 64'h1000) begin fails++; $display("FAIL sd_wdata_addr got=%h/%h exp=deadbeefcafef00d/1000", wd, ad); end
        tests++; if ({wb_valid, mem_err} !== 2'b10) begin fails++; $display("FAIL sd_wb got=%b exp=10", {wb_valid, mem_err}); end
    endtask

    task automatic test_lb();
        int st, bb; logic rq, we, dn; logic [7:0] sb; logic [63:0] wd, ad;
        @(negedge clk);
        drive(1, 0, 3'b000, 64'h1003, 64'h0, 1);
        mem_rdata = 64'h1122_3344_8066_7788;
        run_txn(3, st, bb, rq, we, sb, wd, ad, dn);
        tests++; if (dn !== 1'b1 || st != 3) begin fails++; $display("FAIL lb_stall got=%0d exp=3", st); end
        tests++; if (bb != 0) begin fails++; $display("FAIL lb_bubble got=%0d exp=0", bb); end
        tests++; if (Read_Data_W !== 64'hFFFF_FFFF_FFFF_FF80) begin fails++; $display("FAIL lb_data got=%h exp=ffffffffffffff80", Read_Data_W); end
        tests++; if ({wb_valid, RegWrite_W, MemtoReg_W} !== 3'b111) begin fails++; $display("FAIL lb_ctrl got=%b exp=111", {wb_valid, RegWrite_W, MemtoReg_W}); end
    endtask

    task automatic test_lhu_sb();
        int st, bb; logic rq, we, dn; logic [7:0] sb; logic [63:0] wd, ad;
        @(negedge clk);
        drive(1, 0, 3'b101, 64'h1006, 64'h0, 1);
        mem_rdata = 64'h8001_0000_0000_0000;
        run_txn(1, st, bb, rq, we, sb, wd, ad, dn);
        tests++; if (Read_Data_W !== 64'h8001) begin fails++; $display("FAIL lhu_data got=%h exp=8001", Read_Data_W); end
        @(negedge clk);
        drive(0, 1, 3'b000, 64'h1005, 64'h0000_0000_0000_00A5, 0);
        run_txn(0, st, bb, rq, we, sb, wd, ad, dn);
        tests++; if (sb !== 8'h20 || wd[47:40] !== 8'hA5) begin fails++; $display("FAIL sb_strb got=%h/%h exp=20/a5", sb, wd[47:40]); end
    endtask

    task automatic test_branch();
        logic b, z, v; logic [63:0] t;
        @(negedge clk);
        idle_inputs();
        in_valid = 1; Branch_S = 1; ZERO_S = 1; Branch_Address_S = 64'h40;
        #1;
        tests++; if ({PCSrc, Branch_Target} !== {1'b1, 64'h40}) begin fails++; $display("FAIL br_taken got=%b/%h exp=1/40", PCSrc, Branch_Target); end
        ZERO_S = 0;
        #1;
        tests++; if (PCSrc !== 1'b0) begin fails++; $display("FAIL br_not_taken got=%b exp=0", PCSrc); end
        for (int i = 0; i < 8; i++) begin
            b = 1'($urandom); z = 1'($urandom); v = 1'($urandom); t = {$urandom, $urandom};
            in_valid = v; Branch_S = b; ZERO_S = z; Branch_Address_S = t;
            #1;
            tests++; if ({PCSrc, Branch_Target} !== {v & b & z, t}) begin fails++; $display("FAIL br_rand got=%b/%h exp=%b/%h", PCSrc, Branch_Target, v & b & z, t); end
        end
    endtask

    task automatic test_non_memop();
        logic [63:0] r;
        @(negedge clk);
        idle_inputs();
        r = {$urandom, $urandom};
        in_valid = 1; RegWrite_S = 1; Result_S = r; RD_S = 5'd9; mem_rdata = 64'hFFFF;
        #1;
        tests++; if ({stall, mem_req} !== 2'b00) begin fails++; $display("FAIL alu_nostall got=%b exp=00", {stall, mem_req}); end
        @(posedge clk); #1;
        tests++; if ({wb_valid, RegWrite_W, Result_W, Read_Data_W, RD_W} !== {1'b1, 1'b1, r, 64'd0, 5'd9}) begin
            fails++; $display("FAIL alu_wb got=%b%b/%h/%h/%0d exp=11/%h/0/9", wb_valid, RegWrite_W, Result_W, Read_Data_W, RD_W, r);
        end
        @(negedge clk);
        in_valid = 0; Result_S = ~r;
        @(posedge clk); #1;
        tests++; if ({wb_valid, Result_W} !== {1'b0, r}) begin fails++; $display("FAIL bubble_hold got=%b/%h exp=0/%h", wb_valid, Result_W, r); end
    endtask

    task automatic test_misalign();
        int st, bb; logic rq, we, dn; logic [7:0] sb; logic [63:0] wd, ad;
        @(negedge clk);
`ifdef MEM_MISALIGN_TRAP_EN
        drive(1, 0, 3'b010, 64'h1002, 64'h0, 1);
        #1;
        tests++; if ({mem_req, stall} !== 2'b00) begin fails++; $display("FAIL trap_noreq got=%b exp=00", {mem_req, stall}); end
        @(posedge clk); #1;
        tests++; if ({wb_valid, mem_err, RegWrite_W} !== 3'b110) begin fails++; $display("FAIL trap_wb got=%b exp=110", {wb_valid, mem_err, RegWrite_W}); end
`else
        drive(1, 0, 3'b010, 64'h1006, 64'h0, 1);
        mem_rdata = 64'h8081_0000_0000_0000;
        run_txn(0, st, bb, rq, we, sb, wd, ad, dn);
        tests++; if (Read_Data_W !== 64'h8081 || mem_err !== 1'b0) begin fails++; $display("FAIL lw_trunc got=%h/%b exp=8081/0", Read_Data_W, mem_err); end
`endif
    endtask

    task automatic test_timeout();
        int st, bb; logic rq, we, dn; logic [7:0] sb; logic [63:0] wd, ad;
        @(negedge clk);
        drive(1, 0, 3'b011, 64'h2000, 64'h0, 1);
        mem_rdata = 64'h1234;
        run_txn(-1, st, bb, rq, we, sb, wd, ad, dn);
        tests++; if (dn !== 1'b1 || st != MAX_WAIT + 1) begin fails++; $display("FAIL to_stall got=%0d exp=%0d", st, MAX_WAIT + 1); end
        tests++; if ({wb_valid, mem_err, RegWrite_W} !== 3'b110) begin fails++; $display("FAIL to_wb got=%b exp=110", {wb_valid, mem_err, RegWrite_W}); end
        tests++; if (Read_Data_W !== 64'd0) begin fails++; $display("FAIL to_data got=%h exp=0", Read_Data_W); end
        idle_inputs();
        #1;
        tests++; if ({stall, mem_req} !== 2'b00) begin fails++; $display("FAIL to_idle got=%b exp=00", {stall, mem_req}); end
        @(posedge clk); #1;
        tests++; if ({wb_valid, mem_err} !== 2'b00) begin fails++; $display("FAIL to_pulse got=%b exp=00", {wb_valid, mem_err}); end
    endtask

    task automatic test_random();
        int st, bb, ackd, off, sz, kind; logic rq, we, dn; logic [7:0] sb; logic [63:0] wd, ad;
        logic [2:0] f3; logic [63:0] addr, data, rdat, exp; logic rw, is_st;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            f3 = 3'($urandom_range(0, 7));
            sz = size_of(f3);
`ifdef MEM_MISALIGN_TRAP_EN
            off = ($urandom_range(0, 7) / sz) * sz;
`else
            off = $urandom_range(0, 7);
`endif
            kind = $urandom_range(0, 2);
            is_st = (kind != 0);
            addr = {32'($urandom), 29'($urandom), 3'(off)};
            data = {$urandom, $urandom}; rdat = {$urandom, $urandom};
            rw = 1'($urandom); ackd = $urandom_range(0, 4);
            drive(kind != 1, is_st, f3, addr, data, rw);
            mem_rdata = rdat;
            exp = is_st ? 64'd0 : exp_load(rdat, f3, off);
            run_txn(ackd, st, bb, rq, we, sb, wd, ad, dn);
            tests++; if (dn !== 1'b1 || st != ackd || bb != 0) begin fails++; $display("FAIL rnd_stall n=%0d got=%0d/%0d exp=%0d/0", n, st, bb, ackd); end
            tests++; if ({rq, we, ad} !== {1'b1, is_st, addr[63:3], 3'b000}) begin fails++; $display("FAIL rnd_req n=%0d got=%b%b/%h exp=1%b/%h", n, rq, we, ad, is_st, {addr[63:3], 3'b000}); end
            if (is_st) begin
                tests++; if ({sb, wd} !== {exp_strb(f3, off), exp_wdata(data, off)}) begin
                    fails++; $display("FAIL rnd_store n=%0d got=%h/%h exp=%h/%h", n, sb, wd, exp_strb(f3, off), exp_wdata(data, off));
                end
            end
            tests++; if (Read_Data_W !== exp) begin fails++; $display("FAIL rnd_load n=%0d f3=%0d off=%0d got=%h exp=%h", n, f3, off, Read_Data_W, exp); end
            tests++; if ({wb_valid, RegWrite_W, mem_err, Result_W} !== {1'b1, rw, 1'b0, addr}) begin
                fails++; $display("FAIL rnd_wb n=%0d got=%b%b%b/%h exp=1%b0/%h", n, wb_valid, RegWrite_W, mem_err, Result_W, rw, addr);
            end
        end
    endtask

    task automatic test_reset_mid_access();
        @(negedge clk);
        drive(1, 0, 3'b011, 64'h3000, 64'h0, 1);
        mem_ack = 0;
        #1;
        tests++; if ({mem_req, stall} !== 2'b11) begin fails++; $display("FAIL rst_pre got=%b exp=11", {mem_req, stall}); end
        @(posedge clk); @(posedge clk);
        #3 reset = 1;
        #1;
        tests++; if ({mem_req, stall} !== 2'b00) begin fails++; $display("FAIL rst_drop got=%b exp=00", {mem_req, stall}); end
        tests++; if ({wb_valid, Result_W, PC_W} !== 129'd0) begin fails++; $display("FAIL rst_regs got=%h exp=0", {wb_valid, Result_W, PC_W}); end
        @(negedge clk);
        idle_inputs();
        reset = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        mem_ack = 0; mem_rdata = 0; reset = 1;
        repeat (2) @(posedge clk);
        test_reset();
        test_sd();
        test_lb();
        test_lhu_sb();
        test_branch();
        test_non_memop();
        test_misalign();
        test_timeout();
        test_random();
        test_reset_mid_access();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
